fir_mac_scheduler: RTL

//  Time-multiplexes one shared 4x4 unsigned multiplier (mul_4bit) across TAPS FIR taps.

---
 rtl/fir_mac_scheduler_pkg.sv | 26 ++
 rtl/fir_mac_scheduler_mul_4bit.sv | 13 +
 rtl/fir_mac_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fir_mac_scheduler_pkg.sv
// Shared definitions for the FIR MAC scheduler: data widths, FSM state encoding
// and a constant-evaluable clog2 helper used to size the accumulator.
package fir_mac_scheduler_pkg;

  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned COEF_W   = 4;
  localparam int unsigned PROD_W   = 8;
  localparam int unsigned ADDR_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_mul_4bit.sv
// Combinational 4x4 unsigned multiplier shared by all taps.
// Ports: i_a (sample), i_b (coefficient), o_r (8-bit product).
module fir_mac_scheduler_mul_4bit
  import fir_mac_scheduler_pkg::*;
(
  input  logic [SAMPLE_W-1:0] i_a,
  input  logic [COEF_W-1:0]   i_b,
  output logic [PROD_W-1:0]   o_r
);

  assign o_r = PROD_W'(i_a) * PROD_W'(i_b);

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared 4x4 multiplier walks TAPS taps per sample.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_data/in_ready     sample input handshake (4-bit unsigned)
//   out_valid/out_data/out_ready  filtered result handshake (OUT_W bits)
//   coef_we/coef_addr/coef_wdata  coefficient write port (IDLE only)
//   cfg_err                       1-cycle pulse when a coefficient write is dropped
// Build option: define FIR_SAT_EN to saturate out_data instead of wrapping.
module fir_mac_scheduler
  import fir_mac_scheduler_pkg::*;
#(
  parameter int unsigned TAPS  = 4,
  parameter int unsigned OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [OUT_W-1:0]    out_data,
  input  logic                out_ready,
  input  logic                coef_we,
  input  logic [ADDR_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0]   coef_wdata,
  output logic                cfg_err
);

  localparam int unsigned ACC_W = PROD_W + clog2(TAPS);

  state_t                r_state, w_state_nxt;
  logic [SAMPLE_W-1:0]   r_delay [TAPS];
  logic [COEF_W-1:0]     r_coef  [TAPS];
  logic [ADDR_W-1:0]     r_tap_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_acc_sum;
  logic [OUT_W-1:0]      r_out_data;
  logic [OUT_W-1:0]      w_out_nxt;
  logic                  r_in_ready, r_out_valid, r_cfg_err;
  logic                  w_in_ready_nxt, w_out_valid_nxt;
  logic                  w_accept, w_coef_ok, w_last_tap;
  logic [SAMPLE_W-1:0]   w_mul_a;
  logic [COEF_W-1:0]     w_mul_b;
  logic [PROD_W-1:0]     w_prod;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

  assign w_accept   = (r_state == ST_IDLE) && in_valid;
  assign w_coef_ok  = coef_we && (r_state == ST_IDLE) && (32'(coef_addr) < TAPS);
  assign w_last_tap = (r_tap_cnt == ADDR_W'(TAPS - 1));

  // Tap mux feeding the shared multiplier.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    for (int unsigned k = 0; k < TAPS; k++) begin
      if (r_tap_cnt == ADDR_W'(k)) begin
        w_mul_a = r_delay[k];
        w_mul_b = r_coef[k];
      end
    end
  end

  fir_mac_scheduler_mul_4bit u_mul_4bit (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_r (w_prod)
  );

  // Accumulate and reduce to the output width.
  always_comb begin
    w_acc_sum = r_acc + ACC_W'(w_prod);
`ifdef FIR_SAT_EN
    if ((OUT_W < ACC_W) && (w_acc_sum > ACC_W'((64'd1 << OUT_W) - 64'd1))) begin
      w_out_nxt = '1;
    end else begin
      w_out_nxt = OUT_W'(w_acc_sum);
    end
`else
    w_out_nxt = OUT_W'(w_acc_sum);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and next-cycle output flags.
  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (in_valid)   w_state_nxt = ST_MAC;
      ST_MAC:  if (w_last_tap) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
    w_in_ready_nxt  = (w_state_nxt == ST_IDLE);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
  end

  // Registered handshake flags and write-drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_cfg_err   <= coef_we && !w_coef_ok;
    end
  end

  // Delay line: newest sample at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) r_delay[k] <= '0;
    end else if (w_accept) begin
      r_delay[0] <= in_data;
      for (int unsigned k = 1; k < TAPS; k++) r_delay[k] <= r_delay[k-1];
    end
  end

  // Coefficient register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) r_coef[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        if (w_coef_ok && (coef_addr == ADDR_W'(k))) r_coef[k] <= coef_wdata;
      end
    end
  end

  // Tap counter, accumulator and result latch (captured on the final tap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_cnt  <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (w_accept) begin
      r_tap_cnt <= '0;
      r_acc     <= '0;
    end else if (r_state == ST_MAC) begin
      r_tap_cnt <= r_tap_cnt + ADDR_W'(1);
      r_acc     <= w_acc_sum;
      if (w_last_tap) r_out_data <= w_out_nxt;
    end
  end

endmodule
